// File: rtl/load_store_sequencer.sv
// load_store_sequencer
//   Multicycle sequencer for RISC-V loads and stores on a 64-bit, little-endian
//   doubleword memory. One start pulse in IDLE launches one access. Sub-doubleword
//   stores use read-modify-write. Load results are sign- or zero-extended. A
//   misaligned access or an illegal funct3 completes at once with fault set, and
//   no memory access takes place.
// Ports
//   CLK, RST      clock (rising edge), synchronous active-high reset
//   start         access request, sampled only in IDLE
//   is_store      1 = store, 0 = load
//   funct3        access size and signedness (instr[14:12])
//   addr          byte address
//   store_data    rs2 value; the low bytes are used, depending on the size
//   mem_raddress  doubleword read address
//   mem_waddress  doubleword write address
//   mem_wdata     64-bit write word
//   mem_wr        one-cycle write strobe
//   mem_rdata     read data, valid MEM_RD_LAT cycles after the address is stable
//   load_data     extended load result; it is held until the next load completes
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse
//   fault         valid only together with done
module load_store_sequencer #(
  parameter int MEM_RD_LAT = 1  // legal 1..3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  output logic [63:0] mem_raddress,
  output logic [63:0] mem_waddress,
  output logic [63:0] mem_wdata,
  output logic        mem_wr,
  input  logic [63:0] mem_rdata,
  output logic [63:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [1:0] RD_CNT_INIT = 2'(MEM_RD_LAT - 1);

  state_t      state_q, state_d;
  logic        st_q, st_d;
  logic [2:0]  f3_q, f3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] sdata_q, sdata_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] ldata_q, ldata_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;

  // Legality of the incoming request. This is evaluated on the raw inputs,
  // because a bad request is rejected in the same cycle that it is accepted.
  logic req_illegal, req_misalign;
  always_comb begin
    req_illegal = is_store ? funct3[2] : (funct3 == 3'b111);
    case (funct3[1:0])
      2'b00:   req_misalign = 1'b0;
      2'b01:   req_misalign = addr[0];
      2'b10:   req_misalign = |addr[1:0];
      default: req_misalign = |addr[2:0];
    endcase
  end

  // The addressed lane is moved down to bit 0 for loads and shifted up into
  // place for stores.
  logic [5:0]  lane_sh;
  logic [63:0] rd_shift, ld_ext, size_mask, merged;
  assign lane_sh  = {addr_q[2:0], 3'b000};
  assign rd_shift = mem_rdata >> lane_sh;

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{56{rd_shift[7]}},  rd_shift[7:0]};
      3'b001:  ld_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  ld_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
      3'b100:  ld_ext = {56'd0, rd_shift[7:0]};
      3'b101:  ld_ext = {48'd0, rd_shift[15:0]};
      3'b110:  ld_ext = {32'd0, rd_shift[31:0]};
      default: ld_ext = rd_shift;
    endcase
    case (f3_q[1:0])
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    merged = (mem_rdata & ~(size_mask << lane_sh)) | ((sdata_q & size_mask) << lane_sh);
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    cnt_d   = cnt_q;
    fault_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        st_d    = is_store;
        f3_d    = funct3;
        addr_d  = addr;
        sdata_d = store_data;
        if (req_illegal || req_misalign) begin
          state_d = DONE;
          fault_d = 1'b1;
        end else if (is_store && funct3[1:0] == 2'b11) begin
          // A full doubleword store needs no read.
          state_d = WR;
          wdata_d = store_data;
        end else begin
          state_d = RD;
          cnt_d   = RD_CNT_INIT;
        end
      end
      RD: if (cnt_q == 2'd0) begin
        if (st_q) begin
          state_d = WR;
          wdata_d = merged;
        end else begin
          state_d = DONE;
          ldata_d = ld_ext;
        end
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
      WR:      state_d = DONE;
      default: state_d = IDLE;
    endcase
    // The outputs are registered so that they line up with the state they describe.
    wr_d   = (state_d == WR);
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      st_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 64'd0;
      sdata_q <= 64'd0;
      wdata_q <= 64'd0;
      ldata_q <= 64'd0;
      cnt_q   <= 2'd0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign mem_raddress = {addr_q[63:3], 3'b000};
  assign mem_waddress = {addr_q[63:3], 3'b000};
  assign mem_wdata    = wdata_q;
  assign mem_wr       = wr_q;
  assign load_data    = ldata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_load_store_sequencer.sv
// Bench for load_store_sequencer. Two instances (MEM_RD_LAT 1 and 3) share one
// stimulus stream. Each instance has its own latency-modelled memory. Expected
// results come from a byte-level reference model of memory and load_data.
module tb_load_store_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst, start, is_store;
  logic [2:0]  funct3;
  logic [63:0] addr, store_data;

  logic [1:0][63:0] raddr, waddr, wdata, rdata, ldata;
  logic [1:0]       wr, busy, done, fault;

  int n_cmp = 0;
  int n_err = 0;

  load_store_sequencer #(.MEM_RD_LAT(1)) u_dut1 (
    .CLK(clk), .RST(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .mem_raddress(raddr[0]),
    .mem_waddress(waddr[0]), .mem_wdata(wdata[0]), .mem_wr(wr[0]),
    .mem_rdata(rdata[0]), .load_data(ldata[0]), .busy(busy[0]), .done(done[0]),
    .fault(fault[0]));

  load_store_sequencer #(.MEM_RD_LAT(3)) u_dut3 (
    .CLK(clk), .RST(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .mem_raddress(raddr[1]),
    .mem_waddress(waddr[1]), .mem_wdata(wdata[1]), .mem_wr(wr[1]),
    .mem_rdata(rdata[1]), .load_data(ldata[1]), .busy(busy[1]), .done(done[1]),
    .fault(fault[1]));

  function automatic int lat(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Memory per instance. Read data shows a poison value until the address has
  // been stable for MEM_RD_LAT cycles.
  logic [63:0] mem [2][256];
  logic [63:0] prev_ra [2];
  logic [2:0]  stab_q [2];
  logic [2:0]  stab_now [2];

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      stab_now[k] = (raddr[k] == prev_ra[k]) ?
                    ((stab_q[k] == 3'd7) ? 3'd7 : stab_q[k] + 3'd1) : 3'd0;
      rdata[k] = (int'(stab_now[k]) >= lat(k) - 1) ? mem[k][raddr[k][10:3]]
                                                   : 64'hDEAD_BEEF_DEAD_BEEF;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      prev_ra[k] <= raddr[k];
      stab_q[k]  <= stab_now[k];
      if (wr[k]) mem[k][waddr[k][10:3]] <= wdata[k];
    end
  end

  // Reference model state
  logic [63:0] ref_mem [256];
  logic [63:0] ld_model;

  function automatic int sz_of(logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_fault(bit st, logic [2:0] f3, logic [63:0] a);
    bit illegal = st ? (f3 >= 3'd4) : (f3 == 3'd7);
    return illegal || ((int'(a[2:0]) % sz_of(f3)) != 0);
  endfunction

  function automatic logic [63:0] model_load(logic [2:0] f3, logic [63:0] a);
    logic [63:0] dw = ref_mem[a[10:3]];
    logic [63:0] v  = 64'd0;
    int sz  = sz_of(f3);
    int off = int'(a[2:0]);
    for (int b = 0; b < sz; b++) v[8*b +: 8] = dw[8*(off+b) +: 8];
    if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
    return v;
  endfunction

  function automatic logic [63:0] model_store(logic [2:0] f3, logic [63:0] a, logic [63:0] d);
    logic [63:0] dw = ref_mem[a[10:3]];
    int off = int'(a[2:0]);
    for (int b = 0; b < sz_of(f3); b++) dw[8*(off+b) +: 8] = d[8*b +: 8];
    return dw;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One access. When poke is set, start stays high during the first busy
  // cycle as well, and the sequencer must ignore it.
  task automatic acc(input bit st, input logic [2:0] f3, input logic [63:0] a,
                     input logic [63:0] d, input bit poke);
    bit flt = is_fault(st, f3, a);
    logic [63:0] exp_wd = 64'd0;
    logic [63:0] wa = {a[63:3], 3'b000};
    int n, rel;
    int exp_done [2];
    int exp_wr [2];
    if (!flt && st)  exp_wd   = model_store(f3, a, d);
    if (!flt && !st) ld_model = model_load(f3, a);
    for (int k = 0; k < 2; k++) begin
      if (flt)              exp_done[k] = 1;
      else if (!st)         exp_done[k] = 1 + lat(k);
      else if (f3 == 3'd3)  exp_done[k] = 2;
      else                  exp_done[k] = 2 + lat(k);
      exp_wr[k] = (flt || !st) ? -1 : exp_done[k] - 1;
    end
    @(posedge clk); #1;
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
    n = cyc;
    @(posedge clk); #1;
    // Changes to the inputs after capture must have no effect.
    start = poke; is_store = 1'($urandom); funct3 = 3'($urandom);
    addr = {$urandom, $urandom}; store_data = {$urandom, $urandom};
    for (int t = 1; t <= 7; t++) begin
      rel = cyc - n;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy%0d_r%0d", k, rel), 64'(busy[k]), 64'(rel <= exp_done[k]));
        chk($sformatf("done%0d_r%0d", k, rel), 64'(done[k]), 64'(rel == exp_done[k]));
        chk($sformatf("fault%0d_r%0d", k, rel), 64'(fault[k]), 64'(rel == exp_done[k] && flt));
        chk($sformatf("wr%0d_r%0d", k, rel), 64'(wr[k]), 64'(rel == exp_wr[k]));
        if (rel == exp_wr[k]) begin
          chk($sformatf("waddr%0d", k), waddr[k], wa);
          chk($sformatf("wdata%0d", k), wdata[k], exp_wd);
        end
        if (rel == exp_done[k]) chk($sformatf("ldata%0d", k), ldata[k], ld_model);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int k = 0; k < 2; k++) chk($sformatf("ldata_hold%0d", k), ldata[k], ld_model);
    if (!flt && st) ref_mem[a[10:3]] = exp_wd;
  endtask

  task automatic chk_const(input string tag, input logic [63:0] exp);
    for (int k = 0; k < 2; k++) chk($sformatf("%s_%0d", tag, k), ldata[k], exp);
  endtask

  task automatic chk_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_raddr%0d", tag, k), raddr[k], 64'd0);
      chk($sformatf("%s_waddr%0d", tag, k), waddr[k], 64'd0);
      chk($sformatf("%s_wdata%0d", tag, k), wdata[k], 64'd0);
      chk($sformatf("%s_ldata%0d", tag, k), ldata[k], 64'd0);
      chk($sformatf("%s_ctl%0d", tag, k), {60'd0, wr[k], busy[k], done[k], fault[k]}, 64'd0);
    end
  endtask

  // A reset while an sh is in RD must abort it, with no write.
  task automatic rst_mid(input logic [63:0] a);
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b1; funct3 = 3'd1; addr = a; store_data = 64'hFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) chk($sformatf("rstmid_busy%0d", k), 64'(busy[k]), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ld_model = 64'd0;
    chk_reset_state("rstmid");
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++)
        chk($sformatf("rstmid_idle%0d", k), {62'd0, wr[k], busy[k]}, 64'd0);
    end
  endtask

  initial begin
    logic [63:0] v, a;
    bit st;
    logic [2:0] f3;
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 64'd0; store_data = 64'd0; ld_model = 64'd0;
    for (int i = 0; i < 256; i++) begin
      v = (i == 2) ? 64'h8877665544332211 : {$urandom, $urandom};
      ref_mem[i] = v;
      mem[0][i] <= v;
      mem[1][i] <= v;
    end
    for (int k = 0; k < 2; k++) begin
      prev_ra[k] <= 64'd0;
      stab_q[k]  <= 3'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;

    acc(1'b0, 3'd3, 64'h10, 64'd0, 1'b0);
    chk_const("ld10", 64'h8877665544332211);
    acc(1'b0, 3'd0, 64'h17, 64'd0, 1'b0);
    chk_const("lb17", 64'hFFFFFFFFFFFFFF88);
    acc(1'b0, 3'd4, 64'h17, 64'd0, 1'b0);
    chk_const("lbu17", 64'h88);
    acc(1'b0, 3'd1, 64'h16, 64'd0, 1'b0);
    chk_const("lh16", 64'hFFFFFFFFFFFF8877);
    acc(1'b0, 3'd6, 64'h14, 64'd0, 1'b0);
    chk_const("lwu14", 64'h88776655);

    acc(1'b1, 3'd0, 64'h13, 64'h123456789ABCDEAB, 1'b0);
    acc(1'b0, 3'd3, 64'h10, 64'd0, 1'b0);
    chk_const("sb13", 64'h88776655AB332211);

    acc(1'b1, 3'd2, 64'h12, 64'hCAFEF00D, 1'b1);
    acc(1'b0, 3'd1, 64'h11, 64'd0, 1'b1);
    chk_const("fault_keep", 64'h88776655AB332211);

    rst_mid(64'h22);
    acc(1'b0, 3'd3, 64'h10, 64'd0, 1'b1);
    chk_const("mem_keep", 64'h88776655AB332211);

    acc(1'b1, 3'd3, 64'h18, 64'h0123456789ABCDEF, 1'b0);
    acc(1'b0, 3'd3, 64'h18, 64'd0, 1'b0);
    chk_const("sd18", 64'h0123456789ABCDEF);

    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom);
      f3 = 3'($urandom);
      a  = 64'($urandom_range(0, 2047));
      if ($urandom_range(0, 3) != 0) a = a & ~64'(sz_of(f3) - 1);
      acc(st, f3, a, {$urandom, $urandom}, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
